// File: rtl/qnt_coef_seq.sv
// qnt_coef_seq: one registered valid/ready stage between the DCT and the quantizer.
// Each accepted coefficient is tagged with its coefficient index, block index,
// component (Y/Cb/Cr) and sob/eob/eomcu flags. It also counts completed MCUs.
// Optional build macro QNT_COEF_SEQ_STALL_CNT_EN adds a saturating 32-bit stall counter.
module qnt_coef_seq #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned Y_BLKS = 4,
  parameter int unsigned C_BLKS = 1,
  parameter int unsigned MCU_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_coef_idx,
  output logic [3:0]        out_blk_idx,
  output logic [1:0]        out_comp,
  output logic              out_sob,
  output logic              out_eob,
  output logic              out_eomcu,
  output logic [MCU_W-1:0]  mcu_cnt,
`ifdef QNT_COEF_SEQ_STALL_CNT_EN
  output logic [31:0]       stall_cnt,
`endif
  output logic              busy
);

  if (Y_BLKS == 0 || C_BLKS == 0 || Y_BLKS > 15 || C_BLKS > 15) begin : g_param_err
    $error("qnt_coef_seq: Y_BLKS and C_BLKS must both lie in 1..15");
  end

  typedef enum logic [1:0] {StY = 2'd0, StCb = 2'd1, StCr = 2'd2} comp_e;

  localparam logic [CNT_W-1:0] CoefLast = '1;
  localparam logic [3:0]       YBlkLast = 4'(Y_BLKS - 1);
  localparam logic [3:0]       CBlkLast = 4'(C_BLKS - 1);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]  out_coef_q, out_coef_d;
  logic [3:0]        out_blk_q, out_blk_d;
  logic [1:0]        out_comp_q, out_comp_d;
  logic              out_sob_q, out_sob_d;
  logic              out_eob_q, out_eob_d;
  logic              out_eomcu_q, out_eomcu_d;
  logic [CNT_W-1:0]  coef_q, coef_d;
  logic [3:0]        blk_q, blk_d;
  comp_e             comp_q, comp_d;
  logic [MCU_W-1:0]  mcu_q, mcu_d;
  logic [CNT_W-1:0]  cur_coef;
  logic [3:0]        cur_blk;
  comp_e             cur_comp;
  logic [MCU_W-1:0]  cur_mcu;
  logic              accept, xfer, eob_now;

  // Handshake, position sequencer and output-register next state.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
    xfer     = out_valid_q && out_ready;
    // clr restarts the frame in the same cycle, so a coincident sample sees the origin.
    cur_coef = clr ? '0  : coef_q;
    cur_blk  = clr ? '0  : blk_q;
    cur_comp = clr ? StY : comp_q;
    cur_mcu  = clr ? '0  : mcu_q;
    eob_now  = (cur_coef == CoefLast);

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_coef_d  = out_coef_q;
    out_blk_d   = out_blk_q;
    out_comp_d  = out_comp_q;
    out_sob_d   = out_sob_q;
    out_eob_d   = out_eob_q;
    out_eomcu_d = out_eomcu_q;
    coef_d      = cur_coef;
    blk_d       = cur_blk;
    comp_d      = cur_comp;
    mcu_d       = cur_mcu;

    if (xfer) out_valid_d = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_coef_d  = cur_coef;
      out_blk_d   = cur_blk;
      out_comp_d  = cur_comp;
      out_sob_d   = (cur_coef == '0);
      out_eob_d   = eob_now;
      out_eomcu_d = eob_now && (cur_comp == StCr) && (cur_blk == CBlkLast);
      coef_d      = cur_coef + 1'b1;
      if (eob_now) begin
        blk_d = cur_blk + 4'd1;
        unique case (cur_comp)
          StY: begin
            if (cur_blk == YBlkLast) begin
              comp_d = StCb;
              blk_d  = '0;
            end
          end
          StCb: begin
            if (cur_blk == CBlkLast) begin
              comp_d = StCr;
              blk_d  = '0;
            end
          end
          StCr: begin
            if (cur_blk == CBlkLast) begin
              comp_d = StY;
              blk_d  = '0;
              mcu_d  = cur_mcu + 1'b1;
            end
          end
          default: begin
            comp_d = StY;
            blk_d  = '0;
          end
        endcase
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_coef_q  <= '0;
      out_blk_q   <= '0;
      out_comp_q  <= '0;
      out_sob_q   <= 1'b0;
      out_eob_q   <= 1'b0;
      out_eomcu_q <= 1'b0;
      coef_q      <= '0;
      blk_q       <= '0;
      comp_q      <= StY;
      mcu_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_coef_q  <= out_coef_d;
      out_blk_q   <= out_blk_d;
      out_comp_q  <= out_comp_d;
      out_sob_q   <= out_sob_d;
      out_eob_q   <= out_eob_d;
      out_eomcu_q <= out_eomcu_d;
      coef_q      <= coef_d;
      blk_q       <= blk_d;
      comp_q      <= comp_d;
      mcu_q       <= mcu_d;
    end
  end

`ifdef QNT_COEF_SEQ_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where a held output is refused downstream.
  always_comb begin
    stall_d = stall_q;
    if (clr) begin
      stall_d = '0;
    end else if (out_valid_q && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_coef_idx = out_coef_q;
  assign out_blk_idx  = out_blk_q;
  assign out_comp     = out_comp_q;
  assign out_sob      = out_sob_q;
  assign out_eob      = out_eob_q;
  assign out_eomcu    = out_eomcu_q;
  assign mcu_cnt      = mcu_q;
  assign busy         = out_valid_q || (coef_q != '0) || (blk_q != '0) || (comp_q != StY);

endmodule

// File: tb/tb_qnt_coef_seq.sv
// Bench for qnt_coef_seq: a default 4:2:0 instance and a 4:4:4 instance share one
// stimulus. A stream-position model checks both on every cycle, and directed
// literal checks pin the model.
module tb_qnt_coef_seq;

  localparam int YA = 4, CA = 1, YB = 1, CB = 1;
  localparam int MA = (YA + 2 * CA) * 64;
  localparam int MB = (YB + 2 * CB) * 64;

  logic clk = 1'b0;
  logic rst, clr, in_valid, out_ready;
  logic [11:0] in_data;

  logic a_in_ready, a_out_valid, a_sob, a_eob, a_eomcu, a_busy;
  logic [11:0] a_data;
  logic [5:0] a_coef;
  logic [3:0] a_blk;
  logic [1:0] a_comp;
  logic [15:0] a_mcu;
  logic b_in_ready, b_out_valid, b_sob, b_eob, b_eomcu, b_busy;
  logic [11:0] b_data;
  logic [5:0] b_coef;
  logic [3:0] b_blk;
  logic [1:0] b_comp;
  logic [15:0] b_mcu;
`ifdef QNT_COEF_SEQ_STALL_CNT_EN
  logic [31:0] a_stall, b_stall;
`endif

  always #5 clk = ~clk;

  qnt_coef_seq u_dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_data),
    .out_coef_idx(a_coef), .out_blk_idx(a_blk), .out_comp(a_comp), .out_sob(a_sob),
    .out_eob(a_eob), .out_eomcu(a_eomcu), .mcu_cnt(a_mcu),
`ifdef QNT_COEF_SEQ_STALL_CNT_EN
    .stall_cnt(a_stall),
`endif
    .busy(a_busy)
  );

  qnt_coef_seq #(.Y_BLKS(YB), .C_BLKS(CB)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_data),
    .out_coef_idx(b_coef), .out_blk_idx(b_blk), .out_comp(b_comp), .out_sob(b_sob),
    .out_eob(b_eob), .out_eomcu(b_eomcu), .mcu_cnt(b_mcu),
`ifdef QNT_COEF_SEQ_STALL_CNT_EN
    .stall_cnt(b_stall),
`endif
    .busy(b_busy)
  );

  typedef struct {
    logic [11:0] data;
    int coef, blk, comp;
    bit sob, eob, eomcu;
  } ent_t;

  ent_t qa[$], qb[$];
  int eom_a[$], eom_b[$], sob_a[$];
  int n, stall_m, xfer_cnt, dcnt;
  int checks, failures;
  logic [11:0] last_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Tag of the k-th coefficient since the last clr/rst, from stream arithmetic.
  function automatic ent_t tag(input int k, input int yb, input int cb, input logic [11:0] d);
    ent_t e;
    int mcu_sz, p, b;
    mcu_sz = (yb + 2 * cb) * 64;
    p = k % mcu_sz;
    b = p / 64;
    e.data = d;
    e.coef = p % 64;
    if (b < yb) begin
      e.comp = 0; e.blk = b;
    end else if (b < yb + cb) begin
      e.comp = 1; e.blk = b - yb;
    end else begin
      e.comp = 2; e.blk = b - yb - cb;
    end
    e.sob = (e.coef == 0);
    e.eob = (e.coef == 63);
    e.eomcu = (p == mcu_sz - 1);
    return e;
  endfunction

  task automatic chk_out(input string p, input ent_t e, input logic [11:0] d,
                         input logic [5:0] c, input logic [3:0] b, input logic [1:0] cp,
                         input logic s, input logic eo, input logic em);
    chk({p, "_data"}, d, e.data);
    chk({p, "_coef"}, c, e.coef);
    chk({p, "_blk"}, b, e.blk);
    chk({p, "_comp"}, cp, e.comp);
    chk({p, "_sob"}, s, e.sob);
    chk({p, "_eob"}, eo, e.eob);
    chk({p, "_eomcu"}, em, e.eomcu);
  endtask

  // Per-cycle compare at the falling edge, then advance the model past the next rising edge.
  task automatic model_step;
    bit mv, xf, acc;
    if (rst) begin
      qa.delete(); qb.delete();
      n = 0; stall_m = 0;
      return;
    end
    mv = (qa.size() != 0);
    chk("a_out_valid", a_out_valid, mv);
    chk("b_out_valid", b_out_valid, mv);
    chk("a_in_ready", a_in_ready, !mv || out_ready);
    chk("b_in_ready", b_in_ready, !mv || out_ready);
    chk("a_mcu_cnt", a_mcu, (n / MA) % 65536);
    chk("b_mcu_cnt", b_mcu, (n / MB) % 65536);
    chk("a_busy", a_busy, mv || (n % MA) != 0);
    chk("b_busy", b_busy, mv || (n % MB) != 0);
    if (mv) begin
      chk_out("a", qa[0], a_data, a_coef, a_blk, a_comp, a_sob, a_eob, a_eomcu);
      chk_out("b", qb[0], b_data, b_coef, b_blk, b_comp, b_sob, b_eob, b_eomcu);
    end
`ifdef QNT_COEF_SEQ_STALL_CNT_EN
    chk("a_stall_cnt", a_stall, stall_m);
    chk("b_stall_cnt", b_stall, stall_m);
`endif
    xf = mv && out_ready;
    acc = in_valid && (!mv || out_ready);
    if (xf) begin
      xfer_cnt++;
      if (a_eomcu) eom_a.push_back(xfer_cnt);
      if (b_eomcu) eom_b.push_back(xfer_cnt);
      if (a_sob) sob_a.push_back(xfer_cnt);
      void'(qa.pop_front());
      void'(qb.pop_front());
    end
    if (clr) stall_m = 0;
    else if (mv && !out_ready) stall_m++;
    if (clr) n = 0;
    if (acc) begin
      qa.push_back(tag(n, YA, CA, in_data));
      qb.push_back(tag(n, YB, CB, in_data));
      n++;
    end
  endtask

  task automatic tick;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic next_data;
    dcnt++;
    in_data = 12'(dcnt * 37 + 5);
    last_data = in_data;
  endtask

  task automatic send(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      in_valid = 1'b1;
      next_data();
      tick();
    end
  endtask

  initial begin
    checks = 0; failures = 0; n = 0; stall_m = 0; xfer_cnt = 0; dcnt = 0;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    last_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_mcu_cnt", a_mcu, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_b_busy", b_busy, 0);

    // Three 4:4:4 MCUs == 1.5 default MCUs, at full rate.
    send(576);
    in_valid = 1'b0;
    tick();
    chk("a_eomcu_count", eom_a.size(), 1);
    chk("a_eomcu_pos", eom_a.size() > 0 ? eom_a[0] : -1, 384);
    chk("b_eomcu_count", eom_b.size(), 3);
    chk("b_eomcu_pos0", eom_b.size() > 0 ? eom_b[0] : -1, 192);
    chk("b_eomcu_pos1", eom_b.size() > 1 ? eom_b[1] : -1, 384);
    chk("b_eomcu_pos2", eom_b.size() > 2 ? eom_b[2] : -1, 576);
    chk("a_sob_count", sob_a.size(), 9);
    chk("a_sob_pos5", sob_a.size() > 5 ? sob_a[5] : -1, 321);
    chk("a_mcu_after", a_mcu, 1);
    chk("b_mcu_after", b_mcu, 3);

    // Backpressure mid-block with in_valid held high.
    send(10);
    in_valid = 1'b1;
    out_ready = 1'b0;
    begin
      logic [11:0] held;
      held = last_data;
      next_data();
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("bp_in_ready", a_in_ready, 0);
        chk("bp_out_valid", a_out_valid, 1);
        chk("bp_data_stable", a_data, held);
        chk("bp_coef_stable", a_coef, 9);
      end
    end
`ifdef QNT_COEF_SEQ_STALL_CNT_EN
    chk("bp_stall_cnt", a_stall, 5);
`endif
    out_ready = 1'b1;
    tick();
    chk("bp_release_coef", a_coef, 10);
    send(6);
    in_valid = 1'b0;
    tick();

    // clr on the accept of Cb block 0 coefficient 37.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    send(293);
    chk("pre_clr_coef", a_coef, 36);
    chk("pre_clr_comp", a_comp, 1);
    chk("pre_clr_blk", a_blk, 0);
    in_valid = 1'b1;
    next_data();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_comp", a_comp, 0);
    chk("clr_blk", a_blk, 0);
    chk("clr_coef", a_coef, 0);
    chk("clr_sob", a_sob, 1);
    chk("clr_mcu_cnt", a_mcu, 0);
    send(1);
    in_valid = 1'b0;
    chk("clr_next_coef", a_coef, 1);
    tick();

    // rst while a sample is held under backpressure.
    in_valid = 1'b1;
    out_ready = 1'b0;
    next_data();
    tick();
    chk("rbp_out_valid", a_out_valid, 1);
    chk("rbp_in_ready", a_in_ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rbp_after_valid", a_out_valid, 0);
    chk("rbp_after_busy", a_busy, 0);
    chk("rbp_after_mcu", a_mcu, 0);
    chk("rbp_after_b_busy", b_busy, 0);
`ifdef QNT_COEF_SEQ_STALL_CNT_EN
    chk("rbp_after_stall", a_stall, 0);
`endif
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qnt_coef_seq.md
Name: qnt_coef_seq

Overview:
- Parametrised successor to the single-bit quantizer coefficient counter (qnr.qnt_cnt) in jpeg_encoder.
- Tags each quantizer-input coefficient with its position in the stream:
  - coefficient index within the 8x8 block
  - block index within its component
  - component (Y/Cb/Cr)
  - start/end-of-block and end-of-MCU flags
- Holds one registered valid/ready pipeline stage between the DCT output and the quantizer core.
- Supports configurable chroma subsampling through the block count per component.

Parameters:
- DATA_W, 12, coefficient data width.
- CNT_W, 6, coefficient index width; block size is 2**CNT_W.
- Y_BLKS, 4, luma blocks per MCU (1, 2 or 4); range 1..15.
- C_BLKS, 1, blocks per chroma component per MCU; range 1..15.
- MCU_W, 16, width of the MCU counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  synchronous frame restart; returns the sequence position to Y block 0, coefficient 0.
- in_valid  in  1  input coefficient valid.
- in_ready  out  1  input accept.
- in_data  in  DATA_W  coefficient.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  registered coefficient.
- out_coef_idx  out  CNT_W  coefficient index, 0..2**CNT_W-1.
- out_blk_idx  out  4  block index within the current component.
- out_comp  out  2  component: 0=Y, 1=Cb, 2=Cr.
- out_sob  out  1  first coefficient of a block.
- out_eob  out  1  last coefficient of a block.
- out_eomcu  out  1  last coefficient of the MCU (Cr, last block, last coefficient).
- mcu_cnt  out  MCU_W  number of completed MCUs since rst/clr.
- busy  out  1  out_valid high, or sequence position not at its origin.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid, out_sob, out_eob, out_eomcu = 0.
  - out_data, out_coef_idx, out_blk_idx, out_comp = 0.
  - mcu_cnt = 0.
  - Internal position: coef=0, blk=0, comp=Y.
  - rst overrides clr and any handshake in the same cycle.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - Transfer = out_valid && out_ready.
  - Latency: 1 cycle from accept to out_valid.
  - Full throughput: one coefficient per clk when out_ready is held high.
  - Output fields hold stable while out_valid && !out_ready.
  - out_valid clears after a transfer that has no accept in the same cycle.
- Tagging on accept:
  - The output register loads in_data plus the current position.
  - out_sob = (coef==0).
  - out_eob = (coef==2**CNT_W-1).
  - out_eomcu = out_eob && comp==Cr && blk==C_BLKS-1.
- Position update on accept (component-sequencer states Y, CB, CR):
  - coef increments by 1.
  - At 2**CNT_W-1, coef wraps to 0 and blk increments.
  - In state Y, at blk==Y_BLKS-1 the block wrap moves to CB with blk=0.
  - In state CB, at blk==C_BLKS-1 the block wrap moves to CR with blk=0.
  - In state CR, at blk==C_BLKS-1 the block wrap moves to Y with blk=0, and mcu_cnt increments.
  - mcu_cnt wraps modulo 2**MCU_W.
- No accept: the position is held.
- clr:
  - Sets coef=0, blk=0, comp=Y, mcu_cnt=0. The output register is not flushed.
  - clr together with accept: the accepted sample is tagged coef 0 / blk 0 / Y with out_sob=1, and the position becomes coef=1.
- Out-of-range parameters: Y_BLKS or C_BLKS equal to 0 is a static error, raised by an elaboration-time check.

Optional Feature:
- Macro: QNT_COEF_SEQ_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (32 bits).
  - stall_cnt increments each cycle with out_valid && !out_ready, saturating at 2**32-1.
  - Cleared by rst or clr.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset state: rst held for 2 cycles, then in_valid=0.
  - Required: out_valid=0, mcu_cnt=0, busy=0, in_ready=1.
- Full MCU at full rate (defaults): stream 384 coefficients, out_ready=1.
  - Required: out_comp sequence is Y×256, Cb×64, Cr×64.
  - Required: out_sob high on indices 0, 64, …, 320.
  - Required: out_eomcu only on the 384th output.
  - Required: mcu_cnt=1 afterwards, and the next output has comp=0, blk=0, coef=0.
- Backpressure: out_ready=0 for 5 cycles mid-block, with in_valid held high.
  - Required: one sample is buffered, in_ready=0, and outputs are stable.
  - Required: on release, no duplicated or dropped sample and coefficient indices remain contiguous.
  - Required (macro defined): stall_cnt=5.
- clr mid-stream: assert clr while accepting coefficient 37 of Cb block 0.
  - Required: that sample is tagged comp=0, blk=0, coef=0, sob=1.
  - Required: mcu_cnt=0, and the next sample has coef=1.
- 4:4:4 configuration (Y_BLKS=1, C_BLKS=1), 3 MCUs streamed.
  - Required: out_eomcu on samples 192, 384 and 576.
  - Required: mcu_cnt=3.
- rst during backpressure (out_valid=1, out_ready=0).
  - Required: next cycle out_valid=0, position at origin, busy=0.
